uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Host-side controller for the UART receiver. Drives the receiver's enable and parity-mode configuration from a
//  register file, and captures each completed frame (data byte plus parity-error flag) into a FIFO. It also keeps
//  sticky overrun and parity-error status and raises a level interrupt to the host. It sits between the receiver
//  and an 8-bit single-cycle register bus.
// PARAMETERS
//  FIFO_AW     3   log2 of FIFO depth; depth = 2**FIFO_AW entries, each 9 bits {perr, data[7:0]}
// PORTS
//  clk          in   1          system clock (50 MHz)
//  rst_n        in   1          asynchronous, active-low reset
//  bus_sel      in   1          register access strobe, one cycle per access
//  bus_wr       in   1          write qualifier (with bus_sel)
//  bus_rd       in   1          read qualifier (with bus_sel); bus_wr and bus_rd are never both 1
//  bus_addr     in   3          register address
//  bus_wdata    in   8          write data
//  bus_rdata    out  8          registered read data
//  irq          out  1          level interrupt to host
//  r_rx_en      out  1          receiver enable (= CTRL[0])
//  r_pari_mode  out  2          receiver parity mode, 00 none / 01 odd / 10 even (= CTRL[2:1])
//  rx_data      in   8          receiver data byte; valid from the cycle after int_rx_finish rises
//  int_rx_finish in  1          receiver frame-complete strobe
//  pari_err     in   1          receiver parity error; valid only in the cycle int_rx_finish rises
// BEHAVIOUR
//  Reset: CTRL=0, THRESH=1, FIFO empty (rd/wr ptr=0, count=0), stickies=0, bus_rdata=0, irq=0, r_rx_en=0,
//   r_pari_mode=00. Reset mid-frame or mid-access discards everything; no partial state survives.
//  Register map:
//   0 CTRL   rw  [0] rx_en, [2:1] pari_mode, [3] ien_data, [4] ien_perr, [5] ien_ovr, [7] fifo_clr (write-only;
//            self-clearing, reads 0); [6] reserved, reads 0.
//   1 STATUS r/w1c  [0] empty, [1] full, [2] ovr sticky (W1C), [3] perr sticky (W1C), [4] perr of head entry
//            (0 if empty), [7:5]=0.
//   2 DATA   ro  read returns head data[7:0] and pops. Read when empty returns 0x00 with no pop.
//   3 LEVEL  ro  {0, count[FIFO_AW:0]}.
//   4 THRESH rw  data-interrupt threshold; a value of 0 behaves as 1. Values above depth behave as depth.
//   5-7      reads 0, writes ignored.
//  Bus: writes take effect at the clock edge of the access. Reads are registered: bus_rdata updates the cycle after
//   bus_sel&bus_rd and holds until the next read. A DATA pop happens on the access edge.
//  Capture FSM: IDLE -> (int_rx_finish rising edge, detected with a 1-cycle delayed copy) latch pari_err -> WAIT
//   -> next cycle sample rx_data -> PUSH (push attempt, one cycle) -> IDLE.
//   - Edge detection only: an int_rx_finish level held high for several cycles produces exactly one capture.
//   - Capture is qualified by CTRL.rx_en at the rising edge. If rx_en=0, stay in IDLE and push nothing.
//   - A new rising edge seen in WAIT/PUSH is impossible at legal baud rates. It is ignored.
//  Push/pop rules (same edge):
//   - Push when full: entry dropped, ovr sticky set, count unchanged.
//   - Push and pop together when full: both succeed, count unchanged, no overrun.
//   - Push and pop together when empty: pop ignored, push succeeds, count becomes 1.
//   - Pushing an entry with perr=1 sets the perr sticky (W1C clear loses to a same-cycle set).
//   - Write of fifo_clr=1: pointers and count go to 0 and any same-cycle push or pop is discarded. Stickies are
//     unaffected.
//   - Pointers wrap modulo depth. count is FIFO_AW+1 bits and runs 0..depth.
//  irq (registered, 1-cycle lag):
//   (ien_data & count>=eff_thresh) | (ien_perr & perr_sticky) | (ien_ovr & ovr_sticky).
//   The output tracks r_rx_en / r_pari_mode directly from the CTRL flops. Changing them mid-frame is not guarded.
// TESTING
//  1 Reset then read all registers -> CTRL=00, STATUS=01, LEVEL=00, THRESH=01, irq=0, r_rx_en=0.
//  2 CTRL=0x0B, three frames 0x55,0xA3,0x0F with perr=0 -> LEVEL=3, irq=1 one cycle after the 1st push;
//    DATA reads 55,A3,0F, then STATUS=01 and irq=0.
//  3 CTRL=0x01, 9 frames 0x10..0x18 with no reads -> LEVEL=8, STATUS=0x06; reads return 10..17 (0x18 dropped).
//  4 Frame 0x7E with pari_err=1, ien_perr=1 -> STATUS=0x18, irq=1; write STATUS=0x08 -> perr sticky clear, irq=0.
//  5 FIFO full with a DATA read on the push-cycle edge -> LEVEL stays 8, ovr sticky stays 0; last entry present.
//  6 rx_en=0 frame 0x33 -> LEVEL=0. Set fifo_clr in the same cycle as a push -> LEVEL=0, CTRL[7] reads 0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Host-side controller for the UART receiver: configuration register file, frame capture FSM,
// receive FIFO with sticky overrun/parity status and a level interrupt.
module uart_rx_ctrl #(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_sel,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [2:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       irq,
    output logic       r_rx_en,
    output logic [1:0] r_pari_mode,
    input  logic [7:0] rx_data,
    input  logic       int_rx_finish,
    input  logic       pari_err
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {StIdle, StWait, StPush} cap_state_e;

    cap_state_e         state_q;
    logic               fin_q;
    logic               perr_lat_q;
    logic [7:0]         data_lat_q;

    logic [5:0]         ctrl_q;
    logic [7:0]         thresh_q;
    logic               ovr_q;
    logic               perr_q;
    logic               irq_q;
    logic [7:0]         rdata_q;
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [8:0]         mem [DEPTH];

    logic               wr_acc, rd_acc, ctrl_we, stat_we, thr_we, fifo_clr;
    logic               empty, full, pop, push_req, push, ovr_set, perr_set;
    logic [8:0]         head, count_ext, eff_thresh;
    logic [7:0]         rd_mux;
    logic               irq_d;
    logic               unused_wdata;

    assign unused_wdata = bus_wdata[6];

    assign wr_acc   = bus_sel & bus_wr;
    assign rd_acc   = bus_sel & bus_rd;
    assign ctrl_we  = wr_acc & (bus_addr == 3'd0);
    assign stat_we  = wr_acc & (bus_addr == 3'd1);
    assign thr_we   = wr_acc & (bus_addr == 3'd4);
    assign fifo_clr = ctrl_we & bus_wdata[7];

    assign empty    = (count_q == '0);
    assign full     = (count_q == {1'b1, {FIFO_AW{1'b0}}});
    assign pop      = rd_acc & (bus_addr == 3'd2) & ~empty;
    assign push_req = (state_q == StPush);
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req & (~full | pop);
    assign ovr_set  = push_req & full & ~pop & ~fifo_clr;
    assign perr_set = push & perr_lat_q & ~fifo_clr;

    assign head      = mem[rd_ptr_q];
    assign count_ext = 9'(count_q);

    always_comb begin
        eff_thresh = {1'b0, thresh_q};
        if (thresh_q == 8'd0) begin
            eff_thresh = 9'd1;
        end else if ({1'b0, thresh_q} > 9'(DEPTH)) begin
            eff_thresh = 9'(DEPTH);
        end
    end

    assign irq_d = (ctrl_q[3] & (count_ext >= eff_thresh)) | (ctrl_q[4] & perr_q) |
                   (ctrl_q[5] & ovr_q);

    always_comb begin
        rd_mux = 8'h00;
        case (bus_addr)
            3'd0:    rd_mux = {2'b00, ctrl_q};
            3'd1:    rd_mux = {3'b000, ~empty & head[8], perr_q, ovr_q, full, empty};
            3'd2:    rd_mux = empty ? 8'h00 : head[7:0];
            3'd3:    rd_mux = 8'(count_q);
            3'd4:    rd_mux = thresh_q;
            default: rd_mux = 8'h00;
        endcase
    end

    // Capture FSM: rising edge of int_rx_finish -> latch parity -> sample data -> push attempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fin_q      <= 1'b0;
            perr_lat_q <= 1'b0;
            data_lat_q <= 8'h00;
        end else begin
            fin_q <= int_rx_finish;
            case (state_q)
                StIdle: begin
                    if (int_rx_finish && !fin_q && ctrl_q[0]) begin
                        perr_lat_q <= pari_err;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    data_lat_q <= rx_data;
                    state_q    <= StPush;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= 6'd0;
            thresh_q <= 8'd1;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (ctrl_we) ctrl_q <= bus_wdata[5:0];
            if (thr_we)  thresh_q <= bus_wdata;
            if (rd_acc)  rdata_q <= rd_mux;
            ovr_q  <= (ovr_q & ~(stat_we & bus_wdata[2])) | ovr_set;
            perr_q <= (perr_q & ~(stat_we & bus_wdata[3])) | perr_set;
            irq_q  <= irq_d;
            if (fifo_clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (push && !fifo_clr) mem[wr_ptr_q] <= {perr_lat_q, data_lat_q};
    end

    assign bus_rdata   = rdata_q;
    assign irq         = irq_q;
    assign r_rx_en     = ctrl_q[0];
    assign r_pari_mode = ctrl_q[2:1];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: register access, capture, FIFO edge cases, irq.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bus_sel, bus_wr, bus_rd;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic       irq, r_rx_en;
    logic [1:0] r_pari_mode;
    logic [7:0] rx_data;
    logic       int_rx_finish, pari_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd;

    always #10 clk = ~clk;

    uart_rx_ctrl #(.FIFO_AW(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_sel       (bus_sel),
        .bus_wr        (bus_wr),
        .bus_rd        (bus_rd),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .irq           (irq),
        .r_rx_en       (r_rx_en),
        .r_pari_mode   (r_pari_mode),
        .rx_data       (rx_data),
        .int_rx_finish (int_rx_finish),
        .pari_err      (pari_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_sel = 1'b0; bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        bus_sel = 1'b1; bus_rd = 1'b1; bus_addr = a;
        tick();
        bus_sel = 1'b0; bus_rd = 1'b0;
        d = bus_rdata;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    // Rise at edge 0, data sampled at edge 1, push at edge 2; returns after the push edge.
    task automatic frame(input logic [7:0] d, input logic pe);
        int_rx_finish = 1'b1; pari_err = pe; rx_data = d;
        tick();
        pari_err = 1'b0;
        tick();
        int_rx_finish = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus_sel = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = 3'd0; bus_wdata = 8'h00;
        rx_data = 8'h00; int_rx_finish = 1'b0; pari_err = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: reset state
        check("rst_rdata", bus_rdata, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'h00);
        check("rst_rx_en", {7'd0, r_rx_en}, 8'h00);
        read_check("rst_ctrl", 3'd0, 8'h00);
        read_check("rst_status", 3'd1, 8'h01);
        read_check("rst_level", 3'd3, 8'h00);
        read_check("rst_thresh", 3'd4, 8'h01);

        // 2: three frames with data interrupt enabled
        bus_write(3'd0, 8'h0B);
        check("cfg_rx_en", {7'd0, r_rx_en}, 8'h01);
        check("cfg_pari", {6'd0, r_pari_mode}, 8'h01);
        frame(8'h55, 1'b0);
        check("irq_lag0", {7'd0, irq}, 8'h00);
        tick();
        check("irq_lag1", {7'd0, irq}, 8'h01);
        frame(8'hA3, 1'b0);
        frame(8'h0F, 1'b0);
        read_check("t2_level", 3'd3, 8'h03);
        read_check("t2_d0", 3'd2, 8'h55);
        read_check("t2_d1", 3'd2, 8'hA3);
        read_check("t2_d2", 3'd2, 8'h0F);
        read_check("t2_status", 3'd1, 8'h01);
        check("t2_irq_off", {7'd0, irq}, 8'h00);
        read_check("t2_empty_data", 3'd2, 8'h00);

        // 3: overflow with nine frames
        bus_write(3'd0, 8'h01);
        for (int i = 0; i < 9; i++) frame(8'h10 + 8'(i), 1'b0);
        read_check("t3_level", 3'd3, 8'h08);
        read_check("t3_status", 3'd1, 8'h06);
        for (int i = 0; i < 8; i++) read_check("t3_data", 3'd2, 8'h10 + 8'(i));
        read_check("t3_status_empty", 3'd1, 8'h05);
        bus_write(3'd1, 8'h04);
        read_check("t3_ovr_clr", 3'd1, 8'h01);

        // 4: parity error entry and sticky clear
        bus_write(3'd0, 8'h11);
        frame(8'h7E, 1'b1);
        read_check("t4_status", 3'd1, 8'h18);
        check("t4_irq", {7'd0, irq}, 8'h01);
        bus_write(3'd1, 8'h08);
        read_check("t4_status_clr", 3'd1, 8'h10);
        check("t4_irq_off", {7'd0, irq}, 8'h00);
        read_check("t4_data", 3'd2, 8'h7E);

        // 5: push into full FIFO with a same-edge pop
        bus_write(3'd0, 8'h01);
        for (int i = 0; i < 8; i++) frame(8'h20 + 8'(i), 1'b0);
        int_rx_finish = 1'b1; rx_data = 8'h28;
        tick();
        tick();
        int_rx_finish = 1'b0;
        bus_sel = 1'b1; bus_rd = 1'b1; bus_addr = 3'd2;
        tick();
        bus_sel = 1'b0; bus_rd = 1'b0;
        check("t5_pop", bus_rdata, 8'h20);
        read_check("t5_level", 3'd3, 8'h08);
        read_check("t5_status", 3'd1, 8'h02);
        for (int i = 1; i < 9; i++) read_check("t5_data", 3'd2, 8'h20 + 8'(i));
        read_check("t5_reg5", 3'd5, 8'h00);

        // 6: disabled receiver, then fifo_clr racing a push
        bus_write(3'd0, 8'h00);
        frame(8'h33, 1'b0);
        read_check("t6_level_dis", 3'd3, 8'h00);
        bus_write(3'd0, 8'h01);
        int_rx_finish = 1'b1; rx_data = 8'h44;
        tick();
        tick();
        int_rx_finish = 1'b0;
        bus_write(3'd0, 8'h81);
        read_check("t6_level_clr", 3'd3, 8'h00);
        read_check("t6_ctrl", 3'd0, 8'h01);

        // Threshold: 0 behaves as 1, large value clamps to depth
        bus_write(3'd0, 8'h09);
        bus_write(3'd4, 8'h03);
        frame(8'h01, 1'b0);
        frame(8'h02, 1'b0);
        tick();
        check("thr3_below", {7'd0, irq}, 8'h00);
        frame(8'h03, 1'b0);
        tick();
        check("thr3_at", {7'd0, irq}, 8'h01);
        bus_write(3'd4, 8'hFF);
        tick();
        check("thr_clamp_below", {7'd0, irq}, 8'h00);
        bus_write(3'd0, 8'h89);
        bus_write(3'd4, 8'h00);
        frame(8'h04, 1'b0);
        tick();
        check("thr0_as1", {7'd0, irq}, 8'h01);

        // Reset while a frame is in flight
        int_rx_finish = 1'b1; rx_data = 8'h66;
        tick();
        rst_n = 1'b0;
        tick();
        int_rx_finish = 1'b0;
        rst_n = 1'b1;
        tick(); tick(); tick();
        read_check("rst2_level", 3'd3, 8'h00);
        read_check("rst2_ctrl", 3'd0, 8'h00);
        check("rst2_irq", {7'd0, irq}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
